// File: rtl/note_sequencer_if.sv
// Note-table write bus: the host or ROM loader (master) programs one entry per strobe.
interface note_sequencer_if #(
    parameter int AW    = 3,
    parameter int DIV_W = 16,
    parameter int DUR_W = 12
) ();
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DIV_W-1:0] wr_div;
    logic [DUR_W-1:0] wr_dur;

    modport master (output wr_en, wr_addr, wr_div, wr_dur);
    modport slave  (input  wr_en, wr_addr, wr_div, wr_dur);
endinterface

// File: rtl/note_sequencer.sv
// Plays a programmable note table through one shared, runtime-reloaded modulo-div tone divider,
// with per-note durations in tempo ticks and an optional silent gap between notes.
module note_sequencer #(
    parameter int CLK_HZ    = 12_000_000,
    parameter int TEMPO_HZ  = 1_000,
    parameter int NOTES     = 8,
    parameter int DIV_W     = 16,
    parameter int DUR_W     = 12,
    parameter int GAP_TICKS = 20,
    localparam int AW       = $clog2(NOTES)
) (
    input  logic                clk_in,
    input  logic                rstn,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    note_sequencer_if.slave     wr,
    output logic                tone_out,
    output logic                busy,
    output logic [AW-1:0]       note_idx,
    output logic                done
);
    localparam int TICK   = CLK_HZ / TEMPO_HZ;
    localparam int TICK_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int CNT_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t             state;
    logic [DIV_W-1:0]   tbl_div [NOTES];
    logic [DUR_W-1:0]   tbl_dur [NOTES];
    logic [DIV_W-1:0]   div_q;
    logic [DUR_W-1:0]   dur_q;
    logic [DIV_W-1:0]   tone_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic [CNT_W-1:0]   tick_num;
    logic               played;

    // NOTE: the table must read back as all-zero after reset, so it is built from
    // resettable flops rather than an inferred RAM, which could not be cleared in one cycle.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NOTES; i++) begin
                tbl_div[i] <= '0;
                tbl_dur[i] <= '0;
            end
        end else if (wr.wr_en) begin
            tbl_div[wr.wr_addr] <= wr.wr_div;
            tbl_dur[wr.wr_addr] <= wr.wr_dur;
        end
    end

    logic [DIV_W-1:0] rd_div;
    logic [DUR_W-1:0] rd_dur;
    logic [DIV_W-1:0] tone_next;
    logic             tick_wrap;
    logic             play_last;
    logic             gap_last;
    logic             advance;

    assign rd_div    = tbl_div[note_idx];
    assign rd_dur    = tbl_dur[note_idx];
    assign tone_next = (tone_cnt == div_q - DIV_W'(1)) ? '0 : tone_cnt + DIV_W'(1);
    assign tick_wrap = (tick_cnt == TICK_W'(TICK - 1));
    assign play_last = tick_wrap && (tick_num == CNT_W'(dur_q - DUR_W'(1)));
    assign gap_last  = tick_wrap && (tick_num == GAP_LAST);
    assign advance   = ((state == S_PLAY) && play_last && (GAP_TICKS == 0))
                    || ((state == S_GAP) && gap_last);

    // NOTE: every register below updates with <= so all reads in a cycle see the
    // pre-edge values; the advance block relies on later assignments overriding earlier ones.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            tone_out <= 1'b0;
            busy     <= 1'b0;
            note_idx <= '0;
            done     <= 1'b0;
            div_q    <= '0;
            dur_q    <= '0;
            tone_cnt <= '0;
            tick_cnt <= '0;
            tick_num <= '0;
            played   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                tone_out <= 1'b0;
                note_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        note_idx <= '0;
                        played   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (rd_dur == '0) begin
                            // played is cleared on every restart, so an empty entry 0 always ends
                            if (loop && played) begin
                                note_idx <= '0;
                                played   <= 1'b0;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end else begin
                            div_q    <= rd_div;
                            dur_q    <= rd_dur;
                            tone_cnt <= '0;
                            tick_cnt <= '0;
                            tick_num <= '0;
                            tone_out <= 1'b0;
                            played   <= 1'b1;
                            state    <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        tone_cnt <= tone_next;
                        tone_out <= (div_q >= DIV_W'(2)) && (tone_next >= (div_q >> 1));
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                        if (tick_wrap) tick_num <= tick_num + CNT_W'(1);
                        if (play_last) begin
                            tone_out <= 1'b0;
                            tick_cnt <= '0;
                            tick_num <= '0;
                            state    <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                        if (tick_wrap) tick_num <= tick_num + CNT_W'(1);
                    end
                    default: state <= S_IDLE;
                endcase

                if (advance) begin
                    if (note_idx == AW'(NOTES - 1)) begin
                        if (loop && played) begin
                            note_idx <= '0;
                            played   <= 1'b0;
                            state    <= S_LOAD;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        note_idx <= note_idx + AW'(1);
                        state    <= S_LOAD;
                    end
                end
            end
        end
    end
endmodule
